// File: rtl/cpu_pkg.sv
// Shared processor definitions: datapath widths, the write-back entry format
// and the register-index one-hot decoder.
package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int NREGS     = 8;
    localparam int REG_IDX_W = 3;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] onehot_reg(input logic [REG_IDX_W-1:0] idx);
        logic [NREGS-1:0] one;
        one = {{(NREGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Result intake handshakes and register-file write port of the write-back unit.
interface wb_unit_if;
    import cpu_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_dst;
    logic [DATA_W-1:0]    alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_dst;
    logic [DATA_W-1:0]    mem_data;
    logic [NREGS-1:0]     wr_en;
    logic [DATA_W-1:0]    wr_data;
    logic [NREGS-1:0]     pending;
    logic                 empty;

    modport master (
        output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
        input  alu_ready, mem_ready, wr_en, wr_data, pending, empty
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
        output alu_ready, mem_ready, wr_en, wr_data, pending, empty
    );
endinterface

// File: rtl/wb_fifo.sv
// Write-back buffer: dual push (slot a then slot b), single pop of the head
// every cycle it is non-empty, plus a pending-destination mask.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_a,
    input  wb_entry_t        i_entry_a,
    input  logic             i_push_b,
    input  wb_entry_t        i_entry_b,
    output wb_entry_t        o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic [NREGS-1:0] o_pending
);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic [PTR_W-1:0] w_wptr_b;
    logic [CNT_W-1:0] w_count_next;
    logic [NREGS-1:0] w_pending;

    // Pop, second push slot and occupancy update.
    always_comb begin
        w_pop        = (r_count != {CNT_W{1'b0}});
        w_wptr_b     = r_wptr + {{(PTR_W-1){1'b0}}, 1'b1};
        w_count_next = r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(w_pop);
    end

    // Storage and pointers; a pop clears the head valid before any push reuses that slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_vld   <= {DEPTH{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (i_push_a) begin
                r_vld[r_wptr] <= 1'b1;
                r_mem[r_wptr] <= i_entry_a;
            end
            if (i_push_b) begin
                r_vld[w_wptr_b] <= 1'b1;
                r_mem[w_wptr_b] <= i_entry_b;
            end
            r_wptr  <= r_wptr + PTR_W'(i_push_a) + PTR_W'(i_push_b);
            r_count <= w_count_next;
        end
    end

    // Pending mask over every buffered entry, head included.
    always_comb begin
        w_pending = {NREGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_pending = w_pending | (r_vld[i] ? onehot_reg(r_mem[i].dst) : {NREGS{1'b0}});
        end
    end

    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_pending = w_pending;

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: arbitrates ALU/load results into the buffer (load first)
// and retires the head into the register file every cycle.
module wb_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    wb_unit_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_free;
    logic             w_empty;
    logic [NREGS-1:0] w_pending;
    wb_entry_t        w_head;
    wb_entry_t        w_entry_a;
    wb_entry_t        w_entry_b;
    logic             w_mem_ready;
    logic             w_alu_ready;
    logic             w_mem_take;
    logic             w_alu_take;
    logic             w_push_a;
    logic             w_push_b;

    // Free slots count the head being retired this cycle; load wins a lone slot.
    always_comb begin
        w_free      = CNT_W'(DEPTH) - w_count + CNT_W'(w_count != {CNT_W{1'b0}});
        w_mem_ready = !rst && (w_free >= CNT_W'(1));
        w_alu_ready = !rst && ((w_free >= CNT_W'(2)) ||
                               ((w_free >= CNT_W'(1)) && !bus.mem_valid));
        w_mem_take  = bus.mem_valid && w_mem_ready;
        w_alu_take  = bus.alu_valid && w_alu_ready;
    end

    // Load result occupies slot a when present so the ALU result lands behind it.
    always_comb begin
        w_push_a  = w_mem_take || w_alu_take;
        w_push_b  = w_mem_take && w_alu_take;
        w_entry_b = '{dst: bus.alu_dst, data: bus.alu_data};
        if (w_mem_take) begin
            w_entry_a = '{dst: bus.mem_dst, data: bus.mem_data};
        end else begin
            w_entry_a = w_entry_b;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push_a  (w_push_a),
        .i_entry_a (w_entry_a),
        .i_push_b  (w_push_b),
        .i_entry_b (w_entry_b),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_pending (w_pending)
    );

    // Register-file write port driven straight from buffered state.
    always_comb begin
        bus.alu_ready = w_alu_ready;
        bus.mem_ready = w_mem_ready;
        bus.pending   = w_pending;
        bus.empty     = w_empty;
        if (w_empty) begin
            bus.wr_en   = {NREGS{1'b0}};
            bus.wr_data = {DATA_W{1'b0}};
        end else begin
            bus.wr_en   = onehot_reg(w_head.dst);
            bus.wr_data = w_head.data;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: lockstep queue model plus hand-computed checks.
module tb_wb_unit;

    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [18:0] q[$];
    logic [15:0] rf[8];

    wb_unit_if bus ();

    wb_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the write port.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bus.wr_en[i]) rf[i] <= bus.wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                         input logic av, input logic [2:0] ad, input logic [15:0] adat);
        bus.mem_valid = mv; bus.mem_dst = md; bus.mem_data = mdat;
        bus.alu_valid = av; bus.alu_dst = ad; bus.alu_data = adat;
    endtask

    // One clock with model-predicted readies and write port checked before the edge.
    task automatic cycle();
        int          n;
        int          free;
        logic        emr;
        logic        ear;
        logic [7:0]  een;
        logic [15:0] edat;
        logic [7:0]  epend;
        logic [7:0]  one;
        #1;
        n     = q.size();
        free  = DEPTH - n + ((n != 0) ? 1 : 0);
        emr   = (free >= 1);
        ear   = (free >= 2) || ((free >= 1) && !bus.mem_valid);
        one   = 8'd1;
        een   = 8'd0;
        edat  = 16'd0;
        epend = 8'd0;
        if (n > 0) begin
            een  = one << q[0][18:16];
            edat = q[0][15:0];
        end
        for (int i = 0; i < n; i++) epend = epend | (one << q[i][18:16]);
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, emr});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, ear});
        chk("wr_en",     {24'd0, bus.wr_en},     {24'd0, een});
        chk("wr_data",   {16'd0, bus.wr_data},   {16'd0, edat});
        chk("pending",   {24'd0, bus.pending},   {24'd0, epend});
        chk("empty",     {31'd0, bus.empty},     {31'd0, (n == 0)});
        @(posedge clk);
        if (n > 0) void'(q.pop_front());
        if (bus.mem_valid && emr) q.push_back({bus.mem_dst, bus.mem_data});
        if (bus.alu_valid && ear) q.push_back({bus.alu_dst, bus.alu_data});
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);

        // Reset holds readies low even with offers present.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_wr_en",     {24'd0, bus.wr_en},     32'd0);
        chk("rst_pending",   {24'd0, bus.pending},   32'd0);
        chk("rst_empty",     {31'd0, bus.empty},     32'd1);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        rst = 1'b0;
        #1;
        chk("rel_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("rel_alu_ready", {31'd0, bus.alu_ready}, 32'd1);

        // Single ALU write to R3.
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("single_wr_en",   {24'd0, bus.wr_en},   32'h08);
        chk("single_wr_data", {16'd0, bus.wr_data}, 32'h1234);
        chk("single_pending", {24'd0, bus.pending}, 32'h08);
        cycle();
        chk("single_wr_en_after", {24'd0, bus.wr_en}, 32'h00);
        chk("single_empty_after", {31'd0, bus.empty}, 32'd1);

        // Dual accept to the same register: load first, ALU value wins.
        drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("dual_first",    {16'd0, bus.wr_data}, 32'hAAAA);
        chk("dual_en",       {24'd0, bus.wr_en},   32'h20);
        chk("dual_pend1",    {24'd0, bus.pending}, 32'h20);
        cycle();
        chk("dual_second",   {16'd0, bus.wr_data}, 32'h5555);
        chk("dual_pend2",    {24'd0, bus.pending}, 32'h20);
        cycle();
        chk("dual_r5",       {16'd0, rf[5]},       32'h5555);
        chk("dual_empty",    {31'd0, bus.empty},   32'd1);

        // Fill: two offers per cycle; once full only the load gets in.
        drive(1'b1, 3'd0, 16'h0A00, 1'b1, 3'd1, 16'h0B01);
        cycle();
        drive(1'b1, 3'd2, 16'h0A02, 1'b1, 3'd3, 16'h0B03);
        #1;
        chk("full2_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("full2_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        cycle();
        drive(1'b1, 3'd4, 16'h0A04, 1'b1, 3'd3, 16'h0B03);
        #1;
        chk("full3_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("full3_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h0B03);
        repeat (4) cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        repeat (2) cycle();

        // Back-to-back offers exercising pointer wrap.
        for (int k = 0; k < 20; k++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            cycle();
        end
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        repeat (3) cycle();

        // Asynchronous reset with two buffered entries discards them.
        drive(1'b1, 3'd6, 16'hC0DE, 1'b1, 3'd7, 16'hBEEF);
        cycle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_en",   {24'd0, bus.wr_en},   32'd0);
        chk("arst_pending", {24'd0, bus.pending}, 32'd0);
        chk("arst_empty",   {31'd0, bus.empty},   32'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
